// File: rtl/cdu_agc_counter.sv
// Purpose : CDU inner-gimbal pulse synchronizer, signed pending accumulator, and AGC-side
//           15-bit angle counter fed through a CNTREQ/CNTACK four-phase handshake.
// Latency : a pulse sampled high at edge k reaches PEND at edge k+SYNC_STAGES+1;
//           CNTREQ rises one cycle after PEND first reads nonzero.
// Backpressure: while the AGC withholds CNTACK, pulses accumulate in PEND up to
//           +/-(2^(PEND_W-1)-1); further pulses are dropped and set sticky LOST.
//
// Ports: CLOCKH (clock), rst (async active-high), PLUS_PULSE/MINUS_PULSE (async pulses),
//        AGCZ (sync zero), CNTACK (AGC ack) -> CNTREQ, CNTDIR, CDUCNT, PEND, LOST
//        (+ RATE[7:0] when CDU_RATE_MON_EN is defined).
// Optional feature macro: CDU_RATE_MON_EN (ACK-accept rate monitor over RATE_WIN cycles).
module cdu_agc_counter #(
    parameter int SYNC_STAGES = 2,
    parameter int PEND_W      = 4,
    parameter int CNT_W       = 15
`ifdef CDU_RATE_MON_EN
    ,
    parameter int RATE_WIN    = 1024
`endif
) (
    input  logic              CLOCKH,
    input  logic              rst,
    input  logic              PLUS_PULSE,
    input  logic              MINUS_PULSE,
    input  logic              AGCZ,
    input  logic              CNTACK,
    output logic              CNTREQ,
    output logic              CNTDIR,
    output logic [CNT_W-1:0]  CDUCNT,
    output logic [PEND_W-1:0] PEND,
    output logic              LOST
`ifdef CDU_RATE_MON_EN
    ,
    output logic [7:0]        RATE
`endif
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAITLO} state_t;

    // Two guard bits so the unclamped sum can never wrap before the range check.
    localparam int SW    = PEND_W + 2;
    localparam int LIM_I = (1 << (PEND_W - 1)) - 1;

    state_t                 state;
    logic [SYNC_STAGES-1:0] plus_sync;
    logic [SYNC_STAGES-1:0] minus_sync;
    logic                   plus_last, minus_last;
    logic                   plus_edge, minus_edge;
    logic                   ack_acc;
    logic signed [SW-1:0]   lim_pos, lim_neg, one_s;
    logic signed [SW-1:0]   pend_ext, pend_sum;
    logic [PEND_W-1:0]      pend_nxt;
    logic                   pend_ovf;

    // Synchronizer chains followed by a registered rising-edge detect.
    always_ff @(posedge CLOCKH or posedge rst) begin
        if (rst) begin
            plus_sync  <= '0;
            minus_sync <= '0;
            plus_last  <= 1'b0;
            minus_last <= 1'b0;
            plus_edge  <= 1'b0;
            minus_edge <= 1'b0;
        end else begin
            plus_sync  <= {plus_sync[SYNC_STAGES-2:0], PLUS_PULSE};
            minus_sync <= {minus_sync[SYNC_STAGES-2:0], MINUS_PULSE};
            plus_last  <= plus_sync[SYNC_STAGES-1];
            minus_last <= minus_sync[SYNC_STAGES-1];
            plus_edge  <= plus_sync[SYNC_STAGES-1] & ~plus_last;
            minus_edge <= minus_sync[SYNC_STAGES-1] & ~minus_last;
        end
    end

    assign ack_acc = (state == S_REQ) && CNTACK && !AGCZ;
    assign lim_pos = SW'(LIM_I);
    assign lim_neg = -lim_pos;
    assign one_s   = {{(SW-1){1'b0}}, 1'b1};

    // Net the pulse edges and the accepted transfer, then clamp to the legal range.
    // The transfer uses the latched CNTDIR, so PEND may legitimately cross zero.
    always_comb begin
        pend_ext = signed'({{2{PEND[PEND_W-1]}}, PEND});
        pend_sum = pend_ext;
        if (plus_edge)  pend_sum = pend_sum + one_s;
        if (minus_edge) pend_sum = pend_sum - one_s;
        if (ack_acc)    pend_sum = CNTDIR ? (pend_sum - one_s) : (pend_sum + one_s);
        pend_ovf = 1'b0;
        pend_nxt = pend_sum[PEND_W-1:0];
        if (pend_sum > lim_pos) begin
            pend_nxt = lim_pos[PEND_W-1:0];
            pend_ovf = 1'b1;
        end else if (pend_sum < lim_neg) begin
            pend_nxt = lim_neg[PEND_W-1:0];
            pend_ovf = 1'b1;
        end
    end

    always_ff @(posedge CLOCKH or posedge rst) begin
        if (rst) begin
            state  <= S_IDLE;
            CNTREQ <= 1'b0;
            CNTDIR <= 1'b0;
            CDUCNT <= '0;
            PEND   <= '0;
            LOST   <= 1'b0;
        end else if (AGCZ) begin
            // Zero command discards any edge or ACK arriving in the same cycle.
            state  <= S_IDLE;
            CNTREQ <= 1'b0;
            CDUCNT <= '0;
            PEND   <= '0;
            LOST   <= 1'b0;
        end else begin
            PEND <= pend_nxt;
            if (pend_ovf) LOST <= 1'b1;
            case (state)
                S_IDLE: begin
                    if (PEND != '0) begin
                        CNTDIR <= ~PEND[PEND_W-1];
                        CNTREQ <= 1'b1;
                        state  <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (CNTACK) begin
                        CDUCNT <= CNTDIR ? (CDUCNT + 1'b1) : (CDUCNT - 1'b1);
                        CNTREQ <= 1'b0;
                        state  <= S_WAITLO;
                    end
                end
                S_WAITLO: begin
                    if (!CNTACK) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef CDU_RATE_MON_EN
    localparam int WIN_W = (RATE_WIN > 2) ? $clog2(RATE_WIN) : 1;

    logic [WIN_W-1:0] win_cnt;
    logic [7:0]       acc_cnt;
    logic             win_end;
    logic [7:0]       acc_inc;

    assign win_end = (win_cnt == WIN_W'(RATE_WIN - 1));
    // Saturating increment: stops at 255 within a window.
    assign acc_inc = (ack_acc && acc_cnt != 8'hFF) ? (acc_cnt + 8'd1) : acc_cnt;

    always_ff @(posedge CLOCKH or posedge rst) begin
        if (rst) begin
            win_cnt <= '0;
            acc_cnt <= '0;
            RATE    <= '0;
        end else if (AGCZ) begin
            win_cnt <= '0;
            acc_cnt <= '0;
            RATE    <= '0;
        end else if (win_end) begin
            win_cnt <= '0;
            acc_cnt <= '0;
            RATE    <= acc_inc;
        end else begin
            win_cnt <= win_cnt + 1'b1;
            acc_cnt <= acc_inc;
        end
    end
`endif

endmodule

// File: tb/tb_cdu_agc_counter.sv
module tb_cdu_agc_counter;

    logic        CLOCKH = 1'b0;
    logic        rst;
    logic        PLUS_PULSE, MINUS_PULSE, AGCZ, CNTACK;
    logic        CNTREQ, CNTDIR, LOST;
    logic [14:0] CDUCNT;
    logic [3:0]  PEND;
`ifdef CDU_RATE_MON_EN
    logic [7:0]  RATE;
`endif

    int n_cmp = 0;
    int n_err = 0;

    cdu_agc_counter dut (
        .CLOCKH      (CLOCKH),
        .rst         (rst),
        .PLUS_PULSE  (PLUS_PULSE),
        .MINUS_PULSE (MINUS_PULSE),
        .AGCZ        (AGCZ),
        .CNTACK      (CNTACK),
        .CNTREQ      (CNTREQ),
        .CNTDIR      (CNTDIR),
        .CDUCNT      (CDUCNT),
        .PEND        (PEND),
        .LOST        (LOST)
`ifdef CDU_RATE_MON_EN
        ,
        .RATE        (RATE)
`endif
    );

    always #5 CLOCKH = ~CLOCKH;

    // Advance one clock; inputs change and outputs are read 1 ns after the edge.
    task automatic tick();
        @(posedge CLOCKH);
        #1;
    endtask

    task automatic pulse_plus(input int n);
        for (int i = 0; i < n; i++) begin
            PLUS_PULSE = 1'b1; tick(); tick();
            PLUS_PULSE = 1'b0; tick(); tick();
        end
    endtask

    task automatic pulse_minus(input int n);
        for (int i = 0; i < n; i++) begin
            MINUS_PULSE = 1'b1; tick(); tick();
            MINUS_PULSE = 1'b0; tick(); tick();
        end
    endtask

    task automatic agcz_clear();
        AGCZ = 1'b1; tick();
        AGCZ = 1'b0; tick();
    endtask

    task automatic wait_req(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40 && !ok; i++) begin
            if (CNTREQ) ok = 1'b1;
            else tick();
        end
    endtask

    // Answer one request: ACK raised 2 cycles after CNTREQ is seen, held one cycle.
    task automatic serve_one(output bit ok, output logic dir);
        wait_req(ok);
        dir = CNTDIR;
        if (ok) begin
            tick(); tick();
            CNTACK = 1'b1; tick();
            CNTACK = 1'b0; tick();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; PLUS_PULSE = 0; MINUS_PULSE = 0; AGCZ = 0; CNTACK = 0;
        tick(); tick();
        n_cmp++; if (CNTREQ !== 1'b0) begin n_err++; $display("FAIL reset_cntreq got %b want 0", CNTREQ); end
        n_cmp++; if (CNTDIR !== 1'b0) begin n_err++; $display("FAIL reset_cntdir got %b want 0", CNTDIR); end
        n_cmp++; if (CDUCNT !== 15'h0) begin n_err++; $display("FAIL reset_cducnt got %h want 0", CDUCNT); end
        n_cmp++; if (PEND !== 4'h0) begin n_err++; $display("FAIL reset_pend got %h want 0", PEND); end
        n_cmp++; if (LOST !== 1'b0) begin n_err++; $display("FAIL reset_lost got %b want 0", LOST); end
        rst = 1'b0; tick();
    endtask

    task automatic test_latency();
        bit ok; logic dir;
        agcz_clear();
        PLUS_PULSE = 1'b1;      // sampled at the next edge (k)
        tick(); tick(); tick(); // after edge k+2
        n_cmp++; if (PEND !== 4'h0) begin n_err++; $display("FAIL lat_pend_k2 got %h want 0", PEND); end
        tick();                 // after edge k+3
        n_cmp++; if (PEND !== 4'h1) begin n_err++; $display("FAIL lat_pend_k3 got %h want 1", PEND); end
        n_cmp++; if (CNTREQ !== 1'b0) begin n_err++; $display("FAIL lat_req_k3 got %b want 0", CNTREQ); end
        tick();                 // after edge k+4
        n_cmp++; if (CNTREQ !== 1'b1 || CNTDIR !== 1'b1) begin n_err++; $display("FAIL lat_req_k4 got req=%b dir=%b want 1/1", CNTREQ, CNTDIR); end
        PLUS_PULSE = 1'b0;
        serve_one(ok, dir);
        n_cmp++; if (!ok || CDUCNT !== 15'h0001) begin n_err++; $display("FAIL lat_serve got ok=%b cnt=%h want 1/0001", ok, CDUCNT); end
    endtask

    task automatic test_plus_count();
        bit ok; logic dir;
        agcz_clear();
        pulse_plus(3);
        for (int i = 0; i < 3; i++) begin
            serve_one(ok, dir);
            n_cmp++; if (!ok || dir !== 1'b1) begin n_err++; $display("FAIL plus3_req%0d got ok=%b dir=%b want 1/1", i, ok, dir); end
        end
        tick(); tick(); tick();
        n_cmp++; if (CDUCNT !== 15'd3) begin n_err++; $display("FAIL plus3_cducnt got %h want 0003", CDUCNT); end
        n_cmp++; if (PEND !== 4'h0 || LOST !== 1'b0 || CNTREQ !== 1'b0) begin n_err++; $display("FAIL plus3_idle got pend=%h lost=%b req=%b want 0/0/0", PEND, LOST, CNTREQ); end
    endtask

    task automatic test_wrap();
        bit ok; logic dir;
        agcz_clear();
        pulse_minus(1);
        serve_one(ok, dir);
        n_cmp++; if (!ok || dir !== 1'b0) begin n_err++; $display("FAIL wrap_dn_dir got ok=%b dir=%b want 1/0", ok, dir); end
        n_cmp++; if (CDUCNT !== 15'h7FFF) begin n_err++; $display("FAIL wrap_dn got %h want 7fff", CDUCNT); end
        pulse_plus(1);
        serve_one(ok, dir);
        n_cmp++; if (!ok || CDUCNT !== 15'h0000) begin n_err++; $display("FAIL wrap_up got ok=%b cnt=%h want 1/0000", ok, CDUCNT); end
    endtask

    task automatic test_saturation();
        bit ok; logic dir;
        int served;
        agcz_clear();
        pulse_plus(9);
        n_cmp++; if (PEND !== 4'h7) begin n_err++; $display("FAIL sat_pend got %h want 7", PEND); end
        n_cmp++; if (LOST !== 1'b1) begin n_err++; $display("FAIL sat_lost got %b want 1", LOST); end
        served = 0;
        for (int i = 0; i < 7; i++) begin
            serve_one(ok, dir);
            if (ok && dir === 1'b1) served++;
        end
        n_cmp++; if (served != 7) begin n_err++; $display("FAIL sat_served got %0d want 7", served); end
        tick(); tick(); tick(); tick();
        n_cmp++; if (CNTREQ !== 1'b0) begin n_err++; $display("FAIL sat_extra_req got %b want 0", CNTREQ); end
        n_cmp++; if (CDUCNT !== 15'd7 || PEND !== 4'h0) begin n_err++; $display("FAIL sat_final got cnt=%h pend=%h want 0007/0", CDUCNT, PEND); end
        n_cmp++; if (LOST !== 1'b1) begin n_err++; $display("FAIL sat_lost_sticky got %b want 1", LOST); end
    endtask

    task automatic test_cancel();
        bit saw_req;
        agcz_clear();
        saw_req = 1'b0;
        PLUS_PULSE = 1'b1; MINUS_PULSE = 1'b1; tick(); tick();
        PLUS_PULSE = 1'b0; MINUS_PULSE = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (CNTREQ !== 1'b0 || PEND !== 4'h0) saw_req = 1'b1;
            tick();
        end
        n_cmp++; if (saw_req) begin n_err++; $display("FAIL cancel_activity got req/pend activity want none"); end
        n_cmp++; if (PEND !== 4'h0 || CNTREQ !== 1'b0) begin n_err++; $display("FAIL cancel_final got pend=%h req=%b want 0/0", PEND, CNTREQ); end
    endtask

    task automatic test_dir_latch();
        bit ok; logic dir;
        agcz_clear();
        pulse_plus(1);
        wait_req(ok);
        n_cmp++; if (!ok || CNTDIR !== 1'b1) begin n_err++; $display("FAIL latch_req got ok=%b dir=%b want 1/1", ok, CNTDIR); end
        pulse_minus(2);
        n_cmp++; if (PEND !== 4'hF || CNTDIR !== 1'b1) begin n_err++; $display("FAIL latch_pre got pend=%h dir=%b want f/1", PEND, CNTDIR); end
        CNTACK = 1'b1; tick();
        n_cmp++; if (PEND !== 4'hE) begin n_err++; $display("FAIL latch_ack_pend got %h want e", PEND); end
        n_cmp++; if (CDUCNT !== 15'd1 || CNTREQ !== 1'b0) begin n_err++; $display("FAIL latch_ack_cnt got cnt=%h req=%b want 0001/0", CDUCNT, CNTREQ); end
        CNTACK = 1'b0; tick();
        for (int i = 0; i < 2; i++) begin
            serve_one(ok, dir);
            n_cmp++; if (!ok || dir !== 1'b0) begin n_err++; $display("FAIL latch_minus%0d got ok=%b dir=%b want 1/0", i, ok, dir); end
        end
        n_cmp++; if (CDUCNT !== 15'h7FFF || PEND !== 4'h0) begin n_err++; $display("FAIL latch_final got cnt=%h pend=%h want 7fff/0", CDUCNT, PEND); end
    endtask

    task automatic test_agcz();
        bit ok; logic dir;
        agcz_clear();
        pulse_plus(9);
        for (int i = 0; i < 7; i++) serve_one(ok, dir);
        pulse_plus(3);
        for (int i = 0; i < 3; i++) serve_one(ok, dir);
        pulse_plus(4);
        wait_req(ok);
        n_cmp++; if (!ok || PEND !== 4'h4 || CDUCNT !== 15'd10 || LOST !== 1'b1) begin n_err++; $display("FAIL agcz_setup got ok=%b pend=%h cnt=%h lost=%b want 1/4/000a/1", ok, PEND, CDUCNT, LOST); end
        AGCZ = 1'b1; CNTACK = 1'b1; tick();
        n_cmp++; if (CNTREQ !== 1'b0 || PEND !== 4'h0) begin n_err++; $display("FAIL agcz_clear got req=%b pend=%h want 0/0", CNTREQ, PEND); end
        n_cmp++; if (CDUCNT !== 15'd0 || LOST !== 1'b0) begin n_err++; $display("FAIL agcz_cnt got cnt=%h lost=%b want 0000/0", CDUCNT, LOST); end
        AGCZ = 1'b0;
        tick(); tick(); tick();
        n_cmp++; if (CDUCNT !== 15'd0 || CNTREQ !== 1'b0) begin n_err++; $display("FAIL agcz_ack_ignored got cnt=%h req=%b want 0000/0", CDUCNT, CNTREQ); end
        CNTACK = 1'b0; tick();
    endtask

    task automatic test_async_reset();
        bit ok;
        agcz_clear();
        pulse_plus(1);
        wait_req(ok);
        #2 rst = 1'b1;
        #1;
        n_cmp++; if (CNTREQ !== 1'b0 || PEND !== 4'h0) begin n_err++; $display("FAIL arst_mid got req=%b pend=%h want 0/0", CNTREQ, PEND); end
        tick();
        rst = 1'b0; tick();
    endtask

    initial begin
        test_reset();
        test_latency();
        test_plus_count();
        test_wrap();
        test_saturation();
        test_cancel();
        test_dir_latch();
        test_agcz();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
